pipe_ctrl: RTL

- Pipeline hazard and sequencing controller for the 5-block RV32I core (pc_reg → if_id → id → id_ex → ex).
- Owns every stall, bubble, flush and PC-redirect decision.
- Inputs: decode-stage register usage, ex-stage jump and multi-cycle hold requests.
- Keeps an internal write-pending scoreboard so that read-after-write (RAW) hazards on instructions still in flight stall decode instead of reading stale register data.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_scoreboard.sv | 62 ++++++
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StRaw    = 2'd1,
    StExhold = 2'd2,
    StFlush  = 2'd3
  } state_e;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } sb_entry_t;

  // x0 is never a real dependency, so it can never hit.
  function automatic logic src_hits(input logic used, input logic [4:0] src, input sb_entry_t e);
    return used && (src != ZERO_REG) && e.valid && (e.addr == src);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Write-pending scoreboard: shift register of in-flight destinations plus source match logic.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PEND_DEPTH = 1  // legal 1..3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en_i,
  input  logic       ins_valid_i,
  input  logic [4:0] ins_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic       rs1_used_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs2_used_i,
  output logic       hit1_o,
  output logic       hit2_o,
  output logic       hit1_e0_o,
  output logic       hit2_e0_o
);

  sb_entry_t [PEND_DEPTH-1:0] entries_q, entries_d, shifted;
  sb_entry_t                  new_entry;
  logic      [PEND_DEPTH-1:0] match1, match2;

  always_comb begin
    new_entry.valid = ins_valid_i && (ins_addr_i != ZERO_REG);
    new_entry.addr  = ins_addr_i;
  end

  if (PEND_DEPTH == 1) begin : g_shift_one
    assign shifted = new_entry;
  end else begin : g_shift_many
    assign shifted = {entries_q[PEND_DEPTH-2:0], new_entry};
  end

  always_comb begin
    entries_d = entries_q;
    if (shift_en_i) begin
      entries_d = shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  for (genvar g = 0; g < PEND_DEPTH; g++) begin : g_match
    assign match1[g] = src_hits(rs1_used_i, rs1_addr_i, entries_q[g]);
    assign match2[g] = src_hits(rs2_used_i, rs2_addr_i, entries_q[g]);
  end

  assign hit1_o    = |match1;
  assign hit2_o    = |match2;
  assign hit1_e0_o = match1[0];
  assign hit2_e0_o = match2[0];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, bubbles, flushes and PC redirects.
// Define FORWARD_EN to forward entry0 hits from ex instead of stalling on them.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PEND_DEPTH   = 1,
  parameter int unsigned HOLD_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_addr_i,
  input  logic [4:0]       rs2_addr_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             reg_wen_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_req_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             hold_id_ex_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             fwd_rs1_o,
  output logic             fwd_rs2_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             hold_err_o
);

  localparam int unsigned HoldW = $clog2(HOLD_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               hold_err_q, hold_err_d;

  logic hit1, hit2, hit1_e0, hit2_e0;
  logic jump, hold, raw_stall, fwd1, fwd2;

  assign jump = jump_en_i;
  assign hold = hold_req_i && !jump_en_i;

`ifdef FORWARD_EN
  // Entry0 is the newest producer, so forwarding it is correct even if older entries match too.
  assign raw_stall = !jump && !hold && ((hit1 && !hit1_e0) || (hit2 && !hit2_e0));
  assign fwd1      = !jump && !hold && hit1_e0;
  assign fwd2      = !jump && !hold && hit2_e0;
`else
  logic unused_e0;
  assign unused_e0 = hit1_e0 ^ hit2_e0;
  assign raw_stall = !jump && !hold && (hit1 || hit2);
  assign fwd1      = 1'b0;
  assign fwd2      = 1'b0;
`endif

  pipe_scoreboard #(
    .PEND_DEPTH(PEND_DEPTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en_i  (!hold),
    .ins_valid_i (reg_wen_i && !raw_stall && !jump),
    .ins_addr_i  (rd_addr_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs1_used_i  (rs1_used_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs2_used_i  (rs2_used_i),
    .hit1_o      (hit1),
    .hit2_o      (hit2),
    .hit1_e0_o   (hit1_e0),
    .hit2_e0_o   (hit2_e0)
  );

  // Outputs are forced low while reset is asserted so a mid-stall reset is seen immediately.
  always_comb begin
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    hold_id_ex_o  = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    fwd_rs1_o     = 1'b0;
    fwd_rs2_o     = 1'b0;
    if (rst_n) begin
      fwd_rs1_o = fwd1;
      fwd_rs2_o = fwd2;
      if (jump) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (hold) begin
        hold_pc_o    = 1'b1;
        hold_if_id_o = 1'b1;
        hold_id_ex_o = 1'b1;
      end else if (raw_stall) begin
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = StRun;
    if (jump) begin
      state_d = StFlush;
    end else if (hold) begin
      state_d = StExhold;
    end else if (raw_stall) begin
      state_d = StRaw;
    end

    stall_cnt_d = stall_cnt_q;
    if (hold_pc_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    hold_cnt_d = hold_cnt_q;
    hold_err_d = hold_err_q;
    if (hold) begin
      if (hold_cnt_q != HoldW'(HOLD_TIMEOUT)) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
      if (hold_cnt_q == HoldW'(HOLD_TIMEOUT - 1)) begin
        hold_err_d = 1'b1;
      end
    end else if (!hold_req_i) begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hold_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_err_q  <= hold_err_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign hold_err_o  = hold_err_q;

endmodule
